fp_round_pipe: RTL and testbench
================================

FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

Interface
REQ-001 Parameter NE, default 5: exponent width in bits.
REQ-002 Parameter NF, default 10: stored fraction width in bits.
REQ-003 Parameter NX, default 12: extra bits below the fraction LSB (minimum 2).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts the input beat this cycle.
REQ-008 in_sign  input  1  sign of the unrounded result.
REQ-009 in_exp  input  NE  biased exponent of the normalised unrounded result.
REQ-010 in_frac  input  NF+NX  fraction below the hidden one; bits [NF+NX-1:NX] kept, bits [NX-1:0] discarded.
REQ-011 in_rm  input  3  rounding mode: 000 RNE, 001 RZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RZ.
REQ-012 out_valid  output  1  output beat present.
REQ-013 out_ready  input  1  downstream accepts the output beat.
REQ-014 out_sign / out_exp / out_frac  output  1 / NE / NF  rounded result.
REQ-015 out_nx / out_of  output  1 / 1  inexact and overflow flags for this beat.
REQ-016 flags_clr  input  1  clears the sticky flags.
REQ-017 flags_nx / flags_of  output  1 / 1  sticky accumulated flags.

Function
REQ-018 The block SHALL be a 2-stage pipeline with stage S1 (decision) and stage S2 (increment/exponent fix), each holding one beat and a valid bit.
REQ-019 Latency SHALL be exactly 2 cycles from input handshake to out_valid when out_ready is held high; throughput SHALL be 1 beat per cycle.
REQ-020 S2 SHALL advance when !s2_valid or out_ready; S1 SHALL advance when !s1_valid or S2 advances; in_ready SHALL equal the S1 advance condition (combinational, bubbles collapse).
REQ-021 While out_valid=1 and out_ready=0, the output beat and flags SHALL hold stable.
REQ-022 S1 SHALL compute L=in_frac[NX], G=in_frac[NX-1], R=in_frac[NX-2], T=OR of in_frac[NX-3:0] (T=0 when NX=2).
REQ-023 Round-up decision: RNE G&(L|R|T); RZ 0; RDN sign&(G|R|T); RUP !sign&(G|R|T); RMM G.
REQ-024 nx SHALL equal G|R|T for finite inputs.
REQ-025 S2 SHALL add the round-up bit to the kept fraction at NF+1 bits; on carry out, the fraction SHALL become 0 and the exponent SHALL increment by 1.
REQ-026 If the incremented exponent equals all-ones, overflow applies: out_of=1, out_nx=1; result SHALL be infinity (exp all-ones, frac 0) for RNE, RMM, RUP with sign 0, and RDN with sign 1; otherwise the result SHALL be max finite (exp all-ones minus 1, frac all-ones).
REQ-027 An input with in_exp all-ones (Inf/NaN) SHALL pass through unchanged in its kept fraction bits, with out_nx=0 and out_of=0.
REQ-028 out_sign SHALL always equal in_sign of the same beat.
REQ-029 Sticky flags SHALL OR in out_nx/out_of on each output handshake (out_valid&out_ready).
REQ-030 flags_clr with a handshake in the same cycle SHALL leave the sticky flags equal to that beat's flags (clear first, then set).

Reset
REQ-031 While reset_n=0: s1_valid=0, s2_valid=0, out_valid=0, flags_nx=0, flags_of=0; in_ready=1 from the first cycle after release.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats with no output handshake; the data registers need not be reset.

Verification (NE=5, NF=10, NX=12)
REQ-033 RNE tie-to-even: exp=0x0F, frac kept=0x001, G=1, R=T=0 -> frac 0x002, nx=1; kept=0x002, same tail -> frac 0x002, nx=1.
REQ-034 Carry into exponent: RUP, sign=0, exp=0x0F, kept=0x3FF, T=1 -> exp 0x10, frac 0x000, nx=1, of=0.
REQ-035 Overflow: exp=0x1E, kept=0x3FF, G=1; RNE -> exp 0x1F, frac 0, of=1; RZ -> exp 0x1E, frac 0x3FF, of=0, nx=1; RDN with sign=1 -> infinity, of=1.
REQ-036 Directed modes: sign=1, G=1: RDN rounds up, RUP truncates; rm=101 truncates; exact input (G=R=T=0) -> nx=0 in all modes.
REQ-037 Backpressure: 4 back-to-back beats with out_ready low for 3 cycles -> in_ready drops after 2 accepted beats, no beat lost or duplicated, order preserved, flags accumulate once per beat.
REQ-038 Reset with 2 beats in flight, then flags_clr coinciding with an inexact beat -> no stale out_valid after reset; flags_nx=1 after the clear cycle.

Source files
------------

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage rounding pipeline for normalised FP results.
// S1 forms the guard/round/sticky decision, S2 applies the increment.
module fp_round_pipe #(
   parameter int NE = 5,
   parameter int NF = 10,
   parameter int NX = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [NE-1:0]    in_exp,
   input  logic [NF+NX-1:0] in_frac,
   input  logic [2:0]       in_rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [NE-1:0]    out_exp,
   output logic [NF-1:0]    out_frac,
   output logic             out_nx,
   output logic             out_of,
   input  logic             flags_clr,
   output logic             flags_nx,
   output logic             flags_of
);

   localparam logic [NE-1:0] EMAX = {NE{1'b1}};

   logic s1_adv, s2_adv;
   logic s1_valid_q, s1_sign_q, s1_up_q, s1_nx_q, s1_inf_q;
   logic [NE-1:0] s1_exp_q;
   logic [NF-1:0] s1_kept_q;
   logic out_valid_q, out_sign_q, out_nx_q, out_of_q;
   logic [NE-1:0] out_exp_q;
   logic [NF-1:0] out_frac_q;
   logic flags_nx_q, flags_of_q;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   logic l_bit, g_bit, r_bit, t_bit, special, inexact;
   logic up_d, inf_d;

   assign l_bit = in_frac[NX];
   assign g_bit = in_frac[NX-1];
   assign r_bit = in_frac[NX-2];

   generate
      if (NX > 2) begin : g_sticky
         assign t_bit = |in_frac[NX-3:0];
      end else begin : g_no_sticky
         assign t_bit = 1'b0;
      end
   endgenerate

   assign special = (in_exp == EMAX);
   assign inexact = g_bit | r_bit | t_bit;

   always_comb begin
      up_d  = 1'b0;
      inf_d = 1'b0;
      unique case (in_rm)
         3'b000: begin
            up_d  = g_bit & (l_bit | r_bit | t_bit);
            inf_d = 1'b1;
         end
         3'b010: begin
            up_d  = in_sign & inexact;
            inf_d = in_sign;
         end
         3'b011: begin
            up_d  = !in_sign & inexact;
            inf_d = !in_sign;
         end
         3'b100: begin
            up_d  = g_bit;
            inf_d = 1'b1;
         end
         default: begin
            up_d  = 1'b0;
            inf_d = 1'b0;
         end
      endcase
   end

   logic [NF:0]   sum;
   logic          carry, ovf;
   logic [NE-1:0] exp_inc, exp_d;
   logic [NF-1:0] frac_d;
   logic          nx_d, of_d;

   // Carry out of the fraction renormalises by bumping the exponent.
   always_comb begin
      sum     = {1'b0, s1_kept_q} + {{NF{1'b0}}, s1_up_q};
      carry   = sum[NF];
      exp_inc = s1_exp_q + {{(NE-1){1'b0}}, carry};
      ovf     = carry && (exp_inc == EMAX);
      exp_d   = exp_inc;
      frac_d  = sum[NF-1:0];
      nx_d    = s1_nx_q;
      of_d    = 1'b0;
      if (ovf) begin
         of_d = 1'b1;
         nx_d = 1'b1;
         if (s1_inf_q) begin
            exp_d  = EMAX;
            frac_d = '0;
         end else begin
            exp_d  = EMAX - {{(NE-1){1'b0}}, 1'b1};
            frac_d = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_kept_q  <= '0;
         s1_up_q    <= 1'b0;
         s1_nx_q    <= 1'b0;
         s1_inf_q   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         s1_sign_q  <= in_sign;
         s1_exp_q   <= in_exp;
         s1_kept_q  <= in_frac[NF+NX-1:NX];
         s1_up_q    <= up_d & !special;
         s1_nx_q    <= inexact & !special;
         s1_inf_q   <= inf_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_sign_q  <= 1'b0;
         out_exp_q   <= '0;
         out_frac_q  <= '0;
         out_nx_q    <= 1'b0;
         out_of_q    <= 1'b0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         out_sign_q  <= s1_sign_q;
         out_exp_q   <= exp_d;
         out_frac_q  <= frac_d;
         out_nx_q    <= nx_d;
         out_of_q    <= of_d;
      end
   end

   logic hs, flags_nx_d, flags_of_d;

   // Clear takes effect before the handshake's flags are merged.
   assign hs         = out_valid_q & out_ready;
   assign flags_nx_d = (flags_nx_q & !flags_clr) | (hs & out_nx_q);
   assign flags_of_d = (flags_of_q & !flags_clr) | (hs & out_of_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_nx_q <= 1'b0;
         flags_of_q <= 1'b0;
      end else begin
         flags_nx_q <= flags_nx_d;
         flags_of_q <= flags_of_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sign  = out_sign_q;
   assign out_exp   = out_exp_q;
   assign out_frac  = out_frac_q;
   assign out_nx    = out_nx_q;
   assign out_of    = out_of_q;
   assign flags_nx  = flags_nx_q;
   assign flags_of  = flags_of_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: scoreboard bench with an arithmetic rounding model.
// Directed corner beats, backpressure, reset flush, then random traffic.
module tb_fp_round_pipe;

   localparam int NE = 5;
   localparam int NF = 10;
   localparam int NX = 12;
   localparam logic [NE-1:0] EMAX = '1;

   typedef struct packed {
      logic          s;
      logic [NE-1:0] e;
      logic [NF-1:0] f;
      logic          nx;
      logic          of;
   } res_t;

   logic clk = 1'b0;
   logic reset_n;
   logic in_valid, in_ready, in_sign;
   logic [NE-1:0] in_exp;
   logic [NF+NX-1:0] in_frac;
   logic [2:0] in_rm;
   logic out_valid, out_ready, out_sign;
   logic [NE-1:0] out_exp;
   logic [NF-1:0] out_frac;
   logic out_nx, out_of;
   logic flags_clr, flags_nx, flags_of;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;

   res_t exp_q[$];
   logic mf_nx = 1'b0, mf_of = 1'b0;
   logic stall_prev = 1'b0;
   res_t stall_data;

   fp_round_pipe #(.NE(NE), .NF(NF), .NX(NX)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp),
      .in_frac(in_frac), .in_rm(in_rm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp),
      .out_frac(out_frac), .out_nx(out_nx),
      .out_of(out_of), .flags_clr(flags_clr),
      .flags_nx(flags_nx), .flags_of(flags_of)
   );

   always #5 clk = ~clk;

   // Value-level rounding: compare the discarded tail against one half ulp.
   function automatic res_t model(input logic s, input logic [NE-1:0] e,
                                  input logic [NF+NX-1:0] f,
                                  input logic [2:0] rm);
      res_t r;
      int kept, rem, half, ex;
      bit up, inf;
      kept = int'(f[NF+NX-1:NX]);
      rem  = int'(f[NX-1:0]);
      half = 1 << (NX - 1);
      r.s  = s;
      if (e == EMAX) begin
         r.e  = e;
         r.f  = f[NF+NX-1:NX];
         r.nx = 1'b0;
         r.of = 1'b0;
         return r;
      end
      case (rm)
         3'b000: up = (rem > half) || (rem == half && (kept % 2) == 1);
         3'b010: up = s && rem != 0;
         3'b011: up = !s && rem != 0;
         3'b100: up = rem >= half;
         default: up = 1'b0;
      endcase
      inf = (rm == 3'b000) || (rm == 3'b100) ||
            (rm == 3'b011 && !s) || (rm == 3'b010 && s);
      kept = kept + (up ? 1 : 0);
      ex   = int'(e);
      if (kept == (1 << NF)) begin
         kept = 0;
         ex   = ex + 1;
      end
      r.nx = (rem != 0);
      r.of = 1'b0;
      if (ex == (1 << NE) - 1) begin
         r.of = 1'b1;
         r.nx = 1'b1;
         if (inf) begin
            r.e = EMAX;
            r.f = '0;
         end else begin
            r.e = EMAX - 1'b1;
            r.f = '1;
         end
      end else begin
         r.e = ex[NE-1:0];
         r.f = kept[NF-1:0];
      end
      return r;
   endfunction

   task automatic pin(input string name, input res_t got, input res_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic chk(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b want %b", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Called at posedge+1; returns at posedge+1 just after acceptance.
   task automatic send(input logic s, input logic [NE-1:0] e,
                       input logic [NF-1:0] k, input logic [NX-1:0] t,
                       input logic [2:0] rm);
      logic acc;
      int n;
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_frac  = {k, t};
      in_rm    = rm;
      acc      = 1'b0;
      n        = 0;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got in_ready=0 want 1");
      end
      in_valid = 1'b0;
   endtask

   always begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom % 4) != 0;
         default: out_ready = 1'b0;
      endcase
   end

   // Scoreboard and sticky-flag model, sampled mid-cycle.
   always @(negedge clk) begin
      res_t got, e;
      got = {out_sign, out_exp, out_frac, out_nx, out_of};
      if (!reset_n) begin
         exp_q.delete();
         mf_nx = 1'b0;
         mf_of = 1'b0;
         stall_prev = 1'b0;
         checks++;
         if (out_valid !== 1'b0 || flags_nx !== 1'b0 || flags_of !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b nx=%b of=%b want 0 0 0",
                     out_valid, flags_nx, flags_of);
         end
      end else begin
         checks++;
         if ({flags_nx, flags_of} !== {mf_nx, mf_of}) begin
            errors++;
            $display("FAIL sticky_flags got %b%b want %b%b",
                     flags_nx, flags_of, mf_nx, mf_of);
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || got !== stall_data) begin
               errors++;
               $display("FAIL stall_hold got v=%b %h want v=1 %h",
                        out_valid, got, stall_data);
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in_sign, in_exp, in_frac, in_rm));
         e = got;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spurious_beat got %h want none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL beat got %h want %h", got, e);
               end
            end
         end
         if (flags_clr) begin
            mf_nx = 1'b0;
            mf_of = 1'b0;
         end
         if (out_valid && out_ready) begin
            mf_nx = mf_nx | e.nx;
            mf_of = mf_of | e.of;
         end
         stall_prev = out_valid && !out_ready;
         stall_data = got;
      end
   end

   initial begin
      logic s;
      logic [NE-1:0] e;
      logic [NF-1:0] k;
      logic [NX-1:0] t;
      logic [2:0] rm;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_frac   = '0;
      in_rm     = '0;
      out_ready = 1'b1;
      flags_clr = 1'b0;

      pin("m_rne_up", model(0, 5'h0F, {10'h001, 12'h800}, 3'b000),
          {1'b0, 5'h0F, 10'h002, 1'b1, 1'b0});
      pin("m_rne_even", model(0, 5'h0F, {10'h002, 12'h800}, 3'b000),
          {1'b0, 5'h0F, 10'h002, 1'b1, 1'b0});
      pin("m_carry", model(0, 5'h0F, {10'h3FF, 12'h001}, 3'b011),
          {1'b0, 5'h10, 10'h000, 1'b1, 1'b0});
      pin("m_ovf_rne", model(0, 5'h1E, {10'h3FF, 12'h800}, 3'b000),
          {1'b0, 5'h1F, 10'h000, 1'b1, 1'b1});
      pin("m_ovf_rz", model(0, 5'h1E, {10'h3FF, 12'h800}, 3'b001),
          {1'b0, 5'h1E, 10'h3FF, 1'b1, 1'b0});
      pin("m_ovf_rdn", model(1, 5'h1E, {10'h3FF, 12'h800}, 3'b010),
          {1'b1, 5'h1F, 10'h000, 1'b1, 1'b1});
      pin("m_rdn_neg", model(1, 5'h03, {10'h005, 12'h800}, 3'b010),
          {1'b1, 5'h03, 10'h006, 1'b1, 1'b0});
      pin("m_rup_neg", model(1, 5'h03, {10'h005, 12'h800}, 3'b011),
          {1'b1, 5'h03, 10'h005, 1'b1, 1'b0});
      pin("m_nan", model(0, 5'h1F, {10'h155, 12'hFFF}, 3'b011),
          {1'b0, 5'h1F, 10'h155, 1'b0, 1'b0});

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", in_ready, 1'b1);
      tick();

      send(0, 5'h0F, 10'h001, 12'h800, 3'b000);
      @(negedge clk);
      chk("latency_c1", out_valid, 1'b0);
      @(negedge clk);
      chk("latency_c2", out_valid, 1'b1);
      tick();

      send(0, 5'h0F, 10'h002, 12'h800, 3'b000);
      send(0, 5'h0F, 10'h3FF, 12'h001, 3'b011);
      send(0, 5'h1E, 10'h3FF, 12'h800, 3'b000);
      send(0, 5'h1E, 10'h3FF, 12'h800, 3'b001);
      send(1, 5'h1E, 10'h3FF, 12'h800, 3'b010);
      send(1, 5'h03, 10'h005, 12'h800, 3'b010);
      send(1, 5'h03, 10'h005, 12'h800, 3'b011);
      send(1, 5'h03, 10'h005, 12'h800, 3'b101);
      for (int m = 0; m < 8; m++)
         send(m[0], 5'h07, 10'h2A5, 12'h000, m[2:0]);
      idle(6);

      rdy_mode = 2;
      send(0, 5'h04, 10'h011, 12'h801, 3'b000);
      send(1, 5'h05, 10'h022, 12'h400, 3'b010);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 5'h1E;
      in_frac  = {10'h3FF, 12'hC00};
      in_rm    = 3'b100;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_in_ready_low", in_ready, 1'b0);
         tick();
      end
      rdy_mode = 0;
      send(0, 5'h1E, 10'h3FF, 12'hC00, 3'b100);
      send(0, 5'h06, 10'h033, 12'h001, 3'b001);
      idle(6);

      rdy_mode = 2;
      send(0, 5'h08, 10'h044, 12'h800, 3'b000);
      send(0, 5'h09, 10'h055, 12'h800, 3'b000);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      rdy_mode = 0;
      idle(1);
      @(negedge clk);
      chk("no_stale_valid", out_valid, 1'b0);
      tick();
      send(0, 5'h1E, 10'h3FF, 12'h800, 3'b000);
      idle(4);
      send(0, 5'h0A, 10'h066, 12'h001, 3'b001);
      tick();
      flags_clr = 1'b1;
      @(negedge clk);
      chk("clr_coincide_valid", out_valid, 1'b1);
      tick();
      flags_clr = 1'b0;
      @(negedge clk);
      chk("clr_flags_nx", flags_nx, 1'b1);
      chk("clr_flags_of", flags_of, 1'b0);
      tick();

      rdy_mode = 1;
      for (int b = 0; b < 1500; b++) begin
         idle($urandom_range(0, 2));
         s  = $urandom_range(0, 1) == 1;
         case ($urandom % 8)
            0: e = EMAX;
            1: e = EMAX - 1'b1;
            default: e = NE'($urandom);
         endcase
         k = (($urandom % 4) == 0) ? '1 : NF'($urandom);
         case ($urandom % 6)
            0: t = '0;
            1: t = 12'h800;
            2: t = 12'h001;
            3: t = 12'h400;
            4: t = 12'hC00;
            default: t = NX'($urandom);
         endcase
         rm = 3'($urandom);
         flags_clr = ($urandom % 16) == 0;
         send(s, e, k, t, rm);
         flags_clr = 1'b0;
      end

      rdy_mode = 0;
      idle(10);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
